// File: rtl/fmap_server.sv
// Feature-map buffer: collects a pooled map in raster order, then serves horizontal pixel pairs to the dense stage.
// Optional FMS_RANGE_CHECK_EN builds a sticky out-of-range read flag (range_err); otherwise range_err is tied low.
module fmap_server #(
  parameter int OC      = 15,
  parameter int MAX_COL = 12,
  parameter int PIX     = (MAX_COL + 1) * (MAX_COL + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [8*(OC+1)-1:0]     wr_data,
  output logic                    start,
  input  logic                    rd_en,
  input  logic [4:0]              row,
  input  logic [4:0]              col,
  output logic                    rd_valid,
  output logic [16*(OC+1)-1:0]    data_out,
  input  logic                    done,
  output logic                    range_err,
  output logic                    dbg_serve,
  output logic [$clog2(PIX)-1:0]  dbg_wcnt
);

  localparam int AW = $clog2(PIX);

  typedef enum logic {FILL = 1'b0, SERVE = 1'b1} state_t;

  state_t                 state_q;
  logic [AW-1:0]          wcnt_q;
  logic                   start_q;
  logic                   rd_valid_q;
  logic [16*(OC+1)-1:0]   data_q;
  logic [16*(OC+1)-1:0]   data_d;

  logic [7:0] mem [OC+1][PIX];

  logic          wr_fire;
  logic [9:0]    rd_lin;
  logic [AW-1:0] rd_a0;
  logic [AW-1:0] rd_a1;
  logic          in_range;
  logic          last_col;

  // Write handshake: a beat transfers on an edge where wr_valid && wr_ready; wr_ready is low during reset and in SERVE.
  assign wr_ready = (state_q == FILL) && !rst;
  assign wr_fire  = wr_valid && wr_ready;

  assign rd_lin   = ({5'd0, row} * 10'(MAX_COL + 1)) + {5'd0, col};
  assign rd_a0    = rd_lin[AW-1:0];
  assign rd_a1    = rd_a0 + AW'(1);
  assign in_range = (row <= 5'(MAX_COL)) && (col <= 5'(MAX_COL));
  assign last_col = (col == 5'(MAX_COL));

  // Storage is deliberately not reset; a refill overwrites every entry before the next start.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int c = 0; c <= OC; c++) begin
        mem[c][wcnt_q] <= wr_data[8*c +: 8];
      end
    end
  end

  always_comb begin
    data_d = '0;
    if (in_range) begin
      for (int c = 0; c <= OC; c++) begin
        data_d[16*c +: 8] = mem[c][rd_a0];
        if (!last_col) begin
          data_d[16*c+8 +: 8] = mem[c][rd_a1];
        end
      end
    end
  end

`ifdef FMS_RANGE_CHECK_EN
  logic range_err_q;
  assign range_err = range_err_q;
`else
  assign range_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FILL;
      wcnt_q     <= '0;
      start_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      data_q     <= '0;
`ifdef FMS_RANGE_CHECK_EN
      range_err_q <= 1'b0;
`endif
    end else begin
      start_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      case (state_q)
        FILL: begin
          if (wr_fire) begin
            if (wcnt_q == AW'(PIX - 1)) begin
              wcnt_q  <= '0;
              state_q <= SERVE;
              start_q <= 1'b1;
            end else begin
              wcnt_q <= wcnt_q + AW'(1);
            end
          end
        end
        SERVE: begin
          // A read issued alongside done is still answered before the buffer is released.
          if (rd_en) begin
            rd_valid_q <= 1'b1;
            data_q     <= data_d;
`ifdef FMS_RANGE_CHECK_EN
            if (!in_range) range_err_q <= 1'b1;
`endif
          end
          if (done) state_q <= FILL;
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign start     = start_q;
  assign rd_valid  = rd_valid_q;
  assign data_out  = data_q;
  assign dbg_serve = (state_q == SERVE);
  assign dbg_wcnt  = wcnt_q;

endmodule
